icache_assoc: RTL and testbench
===============================

Name: icache_assoc

Overview:
- Parametrised N-way set-associative instruction cache with multi-word lines.
- Sits between the IF stage and the memory controller. It is the successor to the single-word direct-mapped I-cache.
- Hits return combinationally in the request cycle. A miss triggers a line refill FSM that issues word requests to memory.
- Adds per-set round-robin replacement, whole-cache flush (fence.i) and refill abort on branch mispredict.

Parameters:
- ADDR_W, 32: byte address width.
- DATA_W, 32: instruction word width. Fixed 4-byte words; addr bits [1:0] ignored.
- SETS, 64: number of sets. Power of two, ≥2.
- WAYS, 2: associativity. Power of two, 1..8.
- LINE_WORDS, 4: words per line. Power of two, 1..16.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- branch_error  in  1  mispredict; aborts any refill in progress.
- flush_i  in  1  invalidate entire cache (fence.i).
- request_i  in  1  fetch request from IF, held until done_o.
- addr_i  in  ADDR_W  fetch byte address.
- data_o  out  DATA_W  fetched instruction.
- done_o  out  1  data_o valid this cycle.
- request_o  out  1  word read request to memory controller.
- addr_o  out  ADDR_W  word address of the memory request.
- data_i  in  DATA_W  memory read data.
- done_i  in  1  data_i valid; completes the current memory request.
- wait_i  in  1  memory controller busy; request_o must be low while high.

Behaviour:
- Address split:
  - offset = addr[log2(LINE_WORDS)+1:2]
  - index = next log2(SETS) bits
  - tag = remaining upper bits
- Storage: per set/way valid bit, tag and LINE_WORDS data words; per set one victim pointer of log2(WAYS) bits.
- Reset (async) and flush_i clear all valid bits and victim pointers, and return the FSM to IDLE. Reset outputs: data_o=0, done_o=0, request_o=0, addr_o=0.
- Flush in REFILL discards the partial line. Flush takes priority over an install in the same cycle.
- Hit: request_i && any way with valid && tag match. Same cycle: done_o=1, data_o = matching way's word[offset].
  - More than one way matching is impossible by construction; the bench asserts this.
- No request or miss: done_o=0, data_o=0.
- FSM states IDLE, REFILL.
- IDLE -> REFILL on request_i && miss && !branch_error && !flush_i.
  - Latch line base address (tag, index).
  - Latch victim way: lowest-numbered invalid way, else the victim pointer.
  - word_cnt=0.
- REFILL:
  - request_o = !wait_i, combinational; addr_o = {tag, index, word_cnt, 2'b00}, registered.
  - Each done_i writes data_i into victim way word[word_cnt]; word_cnt++.
  - On done_i with word_cnt==LINE_WORDS-1: set valid and write tag; if the victim was chosen by pointer, advance that set's pointer by 1 mod WAYS; go to IDLE.
  - Refill latency: LINE_WORDS completed memory transactions. The request hits in the cycle after install (request_i still held).
  - Line data is not forwarded to IF before install.
- branch_error in REFILL: go to IDLE the next edge; drop request_o that cycle; valid stays 0 for the victim.
  - Later data for the aborted word is absent because the controller cancels on branch_error. A done_i seen in IDLE is ignored.
- branch_error in IDLE with a miss: no refill starts. Hits still return done_o=1.
- addr_i changes during REFILL (redirect without branch_error): the refill of the latched line completes; the new address is then evaluated in IDLE.
- Victim pointer wraps WAYS-1 -> 0. word_cnt wraps only via the return to IDLE.
- WAYS=1 degenerates to direct-mapped; the victim pointer is unused.

Test Plan:
- Reset, then request addr 0x100 (default params) -> done_o=0 and request_o=1 with addr_o 0x100, 0x104, 0x108, 0x10C on successive done_i. The cycle after the 4th done_i gives done_o=1, data_o=word0. A request to 0x108 then hits in the same cycle.
- Fill 0x000, 0x400, 0x800 (same index, 2 ways) -> 0x800 evicts way0 (0x000). Re-request 0x400 hits. Re-request 0x000 misses and replaces way1 (pointer wrapped).
- Refill of 0x200; assert branch_error after 2 done_i -> request_o=0 next cycle, FSM in IDLE. Request 0x200 misses again and restarts at addr_o 0x200.
- wait_i held high 5 cycles during REFILL -> request_o=0 throughout, addr_o stable, no word_cnt advance. Refill resumes after wait_i drops.
- After filling 0x100, pulse flush_i -> a 0x100 request misses. Asserting rst mid-refill async-clears request_o=0 and addr_o=0 before the next edge.
- Parameter sweep WAYS=1/4, LINE_WORDS=1/8, SETS=16 -> random fetch stream with no done_o=1 data mismatch vs. reference memory model, and never two ways hit.

Source files
------------

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with multi-word lines, per-set
// round-robin replacement, whole-cache flush and refill abort on mispredict.
module icache_assoc #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_error,
  input  logic              flush_i,
  input  logic              request_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              done_o,
  output logic              request_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              done_i,
  input  logic              wait_i
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int OFF_S = (OFF_W > 0) ? OFF_W : 1;
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_S = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
  // Way/word arrays are sized to the index width so degenerate 1-way or
  // 1-word configurations still index cleanly; the spare entries are never valid.
  localparam int NWAY  = 1 << WAY_S;
  localparam int NWORD = 1 << OFF_S;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t            state_q;
  logic [NWAY-1:0]   valid_q [SETS];
  logic [WAY_S-1:0]  ptr_q   [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][NWAY];
  logic [DATA_W-1:0] line_q  [SETS][NWAY][NWORD];

  logic [TAG_W-1:0]  rtag_q;
  logic [IDX_W-1:0]  ridx_q;
  logic [WAY_S-1:0]  rway_q;
  logic              rptr_q;
  logic [OFF_S-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_o_q;

  logic [ADDR_W-3:0] waddr;
  logic [OFF_S-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [NWAY-1:0]   match;
  logic [WAY_S-1:0]  hit_way;
  logic [WAY_S-1:0]  free_way;
  logic              free_found;
  logic              hit;
  logic              last_word;
  logic              install_ok;

  assign waddr = addr_i[ADDR_W-1:2];
  assign off   = OFF_S'(waddr) & OFF_S'(LINE_WORDS - 1);
  assign idx   = IDX_W'(waddr >> OFF_W);
  assign tag   = TAG_W'(waddr >> (OFF_W + IDX_W));

  always_comb begin
    match      = '0;
    hit_way    = '0;
    free_way   = '0;
    free_found = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        match[w] = 1'b1;
        hit_way  = WAY_S'(w);
      end
      if (!valid_q[idx][w] && !free_found) begin
        free_found = 1'b1;
        free_way   = WAY_S'(w);
      end
    end
  end

  assign hit        = request_i && (state_q == IDLE) && (|match);
  assign done_o     = hit;
  assign data_o     = hit ? line_q[idx][hit_way][off] : '0;
  assign request_o  = (state_q == REFILL) && !wait_i && !branch_error && !flush_i;
  assign addr_o     = addr_o_q;
  assign last_word  = (cnt_q == OFF_S'(LINE_WORDS - 1));
  assign install_ok = (state_q == REFILL) && done_i && !branch_error && !flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rtag_q   <= '0;
      ridx_q   <= '0;
      rway_q   <= '0;
      rptr_q   <= 1'b0;
      cnt_q    <= '0;
      addr_o_q <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else if (flush_i) begin
      state_q <= IDLE;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (request_i && !(|match) && !branch_error) begin
            state_q  <= REFILL;
            rtag_q   <= tag;
            ridx_q   <= idx;
            rway_q   <= free_found ? free_way : ptr_q[idx];
            rptr_q   <= !free_found;
            cnt_q    <= '0;
            addr_o_q <= addr_i & ~ADDR_W'(LINE_WORDS * 4 - 1);
            // Invalidate the evicted line up front so a partial refill never hits.
            if (!free_found) valid_q[idx][ptr_q[idx]] <= 1'b0;
          end
        end
        REFILL: begin
          if (branch_error) begin
            state_q <= IDLE;
          end else if (done_i) begin
            if (last_word) begin
              valid_q[ridx_q][rway_q] <= 1'b1;
              if (rptr_q && (WAYS > 1)) ptr_q[ridx_q] <= ptr_q[ridx_q] + 1'b1;
              state_q <= IDLE;
            end else begin
              cnt_q    <= cnt_q + 1'b1;
              addr_o_q <= addr_o_q + ADDR_W'(4);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (install_ok) begin
      line_q[ridx_q][rway_q][cnt_q] <= data_i;
      if (last_word) tag_q[ridx_q][rway_q] <= rtag_q;
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed checks of icache_assoc (default parameters) plus random fetch streams
// on two alternative configurations against a reference memory function.
module tb_icache_assoc;

  logic        clk;
  logic        rst;
  int          n_checks;
  int          n_errors;

  logic        be0, fl0, req0, donei0, wait0;
  logic [31:0] addr0, datai0, data_o0, addro0;
  logic        done_o0, reqo0;

  logic        req1, do1, ro1;
  logic [31:0] addr1, dat1, ao1;
  logic        req2, do2, ro2;
  logic [31:0] addr2, dat2, ao2;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h5A5A_0000;
  endfunction

  icache_assoc #(.ADDR_W(32), .DATA_W(32), .SETS(64), .WAYS(2), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .branch_error(be0), .flush_i(fl0),
    .request_i(req0), .addr_i(addr0), .data_o(data_o0), .done_o(done_o0),
    .request_o(reqo0), .addr_o(addro0), .data_i(datai0), .done_i(donei0),
    .wait_i(wait0)
  );

  icache_assoc #(.ADDR_W(32), .DATA_W(32), .SETS(16), .WAYS(4), .LINE_WORDS(8)) u1 (
    .clk(clk), .rst(rst), .branch_error(1'b0), .flush_i(1'b0),
    .request_i(req1), .addr_i(addr1), .data_o(dat1), .done_o(do1),
    .request_o(ro1), .addr_o(ao1), .data_i(memf(ao1)), .done_i(ro1),
    .wait_i(1'b0)
  );

  icache_assoc #(.ADDR_W(32), .DATA_W(32), .SETS(16), .WAYS(1), .LINE_WORDS(1)) u2 (
    .clk(clk), .rst(rst), .branch_error(1'b0), .flush_i(1'b0),
    .request_i(req2), .addr_i(addr2), .data_o(dat2), .done_o(do2),
    .request_o(ro2), .addr_o(ao2), .data_i(memf(ao2)), .done_i(ro2),
    .wait_i(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [31:0] base, input int from, input int to);
    for (int k = from; k < to; k++) begin
      check("req_o", {31'b0, reqo0}, 32'd1);
      check("addr_o", addro0, base + 32'(4 * k));
      donei0 = 1'b1;
      datai0 = memf(base + 32'(4 * k));
      tick();
      donei0 = 1'b0;
      #1;
    end
  endtask

  task automatic fill0(input logic [31:0] a);
    req0 = 1'b1;
    addr0 = a;
    #1;
    check("miss", {31'b0, done_o0}, 32'd0);
    tick();
    serve(a & ~32'hF, 0, 4);
    check("hit_after_fill", {31'b0, done_o0}, 32'd1);
    check("fill_data", data_o0, memf(a));
  endtask

  // Probing with branch_error held keeps a miss from launching a refill.
  task automatic probe(input logic [31:0] a, input logic exp_hit);
    be0 = 1'b1;
    req0 = 1'b1;
    addr0 = a;
    #1;
    check("probe_hit", {31'b0, done_o0}, {31'b0, exp_hit});
    if (exp_hit) check("probe_data", data_o0, memf(a));
    tick();
    check("probe_no_refill", {31'b0, reqo0}, 32'd0);
    be0 = 1'b0;
    req0 = 1'b0;
  endtask

  task automatic sweep(input int sel, input logic [31:0] a);
    logic        got;
    logic        dn;
    logic [31:0] d;
    int          mh;
    got = 1'b0;
    if (sel == 1) begin req1 = 1'b1; addr1 = a; end
    else begin req2 = 1'b1; addr2 = a; end
    for (int c = 0; c < 64 && !got; c++) begin
      #1;
      if (sel == 1) begin dn = do1; d = dat1; mh = $countones(u1.match); end
      else begin dn = do2; d = dat2; mh = $countones(u2.match); end
      check("sweep_onehot", {31'b0, mh <= 1}, 32'd1);
      if (dn) begin
        check("sweep_data", d, memf(a));
        got = 1'b1;
      end else begin
        @(posedge clk);
      end
    end
    if (!got) check("sweep_timeout", 32'd0, 32'd1);
    req1 = 1'b0;
    req2 = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; be0 = 1'b0; fl0 = 1'b0; req0 = 1'b0; donei0 = 1'b0; wait0 = 1'b0;
    addr0 = '0; datai0 = '0;
    req1 = 1'b0; addr1 = '0; req2 = 1'b0; addr2 = '0;
    tick(); tick();
    check("rst_done", {31'b0, done_o0}, 32'd0);
    check("rst_req", {31'b0, reqo0}, 32'd0);
    check("rst_addr", addro0, 32'd0);
    check("rst_data", data_o0, 32'd0);
    rst = 1'b0;
    tick();

    // basic refill of 0x100 then a same-line hit
    fill0(32'h100);
    addr0 = 32'h108;
    #1;
    check("hit_108", {31'b0, done_o0}, 32'd1);
    check("data_108", data_o0, memf(32'h108));
    req0 = 1'b0;
    tick();

    // round-robin replacement within set 0
    fill0(32'h000);
    fill0(32'h400);
    fill0(32'h800);
    req0 = 1'b0;
    tick();
    probe(32'h400, 1'b1);
    probe(32'h000, 1'b0);
    probe(32'h800, 1'b1);
    fill0(32'h000);
    req0 = 1'b0;
    tick();
    probe(32'h800, 1'b1);
    probe(32'h400, 1'b0);
    probe(32'h000, 1'b1);
    fill0(32'h40C);
    req0 = 1'b0;
    tick();
    probe(32'h800, 1'b0);
    probe(32'h000, 1'b1);

    // abort on branch_error after two words, then restart
    req0 = 1'b1; addr0 = 32'h200;
    #1;
    tick();
    serve(32'h200, 0, 2);
    be0 = 1'b1;
    #1;
    check("abort_req_drop", {31'b0, reqo0}, 32'd0);
    tick();
    be0 = 1'b0;
    #1;
    check("abort_idle_req", {31'b0, reqo0}, 32'd0);
    check("abort_no_hit", {31'b0, done_o0}, 32'd0);
    tick();
    serve(32'h200, 0, 4);
    check("abort_refill_hit", {31'b0, done_o0}, 32'd1);
    check("abort_refill_data", data_o0, memf(32'h200));
    req0 = 1'b0;
    tick();

    // wait_i stalls the refill
    req0 = 1'b1; addr0 = 32'h304;
    #1;
    tick();
    serve(32'h300, 0, 1);
    wait0 = 1'b1;
    repeat (5) begin
      #1;
      check("wait_req", {31'b0, reqo0}, 32'd0);
      check("wait_addr", addro0, 32'h304);
      @(posedge clk);
    end
    #1;
    wait0 = 1'b0;
    #1;
    serve(32'h300, 1, 4);
    check("wait_hit", {31'b0, done_o0}, 32'd1);
    check("wait_data", data_o0, memf(32'h304));
    req0 = 1'b0;
    tick();

    // flush, then async reset during a refill
    probe(32'h100, 1'b1);
    fl0 = 1'b1;
    tick();
    fl0 = 1'b0;
    probe(32'h100, 1'b0);
    probe(32'h000, 1'b0);
    req0 = 1'b1; addr0 = 32'h100;
    #1;
    tick();
    check("pre_rst_req", {31'b0, reqo0}, 32'd1);
    check("pre_rst_addr", addro0, 32'h100);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_req", {31'b0, reqo0}, 32'd0);
    check("async_rst_addr", addro0, 32'd0);
    req0 = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // random fetch streams on the alternative configurations
    for (int i = 0; i < 80; i++) sweep(1, $urandom_range(0, 32'hFFF) & ~32'h3);
    for (int i = 0; i < 80; i++) sweep(2, $urandom_range(0, 32'hFF) & ~32'h3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
